// File: rtl/seq_divider_64.sv
// ---------------------------------------------------------------------------
// seq_divider_64
//
// Purpose:
//   Multi-cycle integer divider for the LEGv8 datapath (UDIV / SDIV).
//   It computes one quotient bit per clock by restoring division on operand
//   magnitudes. A final fix-up cycle restores the signs. The control unit
//   stalls while busy is high and takes the results when done pulses.
//
// Parameters:
//   WIDTH        operand/result width in bits (>= 2), default 64
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        sample operands and begin a division (honoured in IDLE/DONE)
//   is_signed    1 = SDIV (two's complement), 0 = UDIV
//   dividend     numerator (Rn)
//   divisor      denominator (Rm)
//   busy         high while a division is in progress
//   done         one-cycle pulse: quotient/remainder/div_by_zero are valid
//   quotient     result (Rd), truncated toward zero
//   remainder    remainder, sign follows the dividend
//   div_by_zero  last operation had a zero divisor
//
// Timing:
//   start sampled at capture edge C -> WIDTH RUN cycles, one FIX cycle,
//   then done is high in the cycle after edge C+WIDTH+1.
//   A zero divisor skips RUN: capture -> FIX -> DONE.
// ---------------------------------------------------------------------------
module seq_divider_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Set by the FSM in the cycle in which start is accepted.
  logic capture;

  // Working registers of the restoring datapath.
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_div_q;

  // -------------------------------------------------------------------------
  // Operand magnitudes. In unsigned mode the operands pass through untouched.
  // MIN negates to itself. Read as unsigned, that is the correct magnitude
  // 2^(WIDTH-1), so MIN needs no special case anywhere.
  // -------------------------------------------------------------------------
  logic             dividend_neg;
  logic             divisor_neg;
  logic             divisor_zero;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  assign dividend_neg = is_signed & dividend[WIDTH-1];
  assign divisor_neg  = is_signed & divisor[WIDTH-1];
  assign divisor_zero = (divisor == '0);
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

  // -------------------------------------------------------------------------
  // One restoring step. {rem,quo} shifts left by one into a WIDTH+1-bit
  // partial remainder and is compared against the divisor magnitude.
  // rem < divisor holds before every step, so the shifted value is below
  // twice the divisor. The difference therefore always fits in WIDTH bits,
  // and a plain WIDTH-bit subtract gives the correct new remainder.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   shifted;
  logic             step_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign step_ge  = (shifted >= {1'b0, dvs_q});
  assign rem_next = step_ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], step_ge};

  // Sign fix-up applied in the FIX cycle, two's complement mod 2^WIDTH.
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign quo_fixed = neg_quo_q ? -quo_q : quo_q;
  assign rem_fixed = neg_rem_q ? -rem_q : rem_q;

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and status outputs. start is honoured only in IDLE
  // and DONE, which allows back-to-back operations. A zero divisor skips
  // straight to FIX. That keeps busy high for exactly one cycle before DONE.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = divisor_zero ? FIX : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          capture = 1'b1;
          state_d = divisor_zero ? FIX : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. On capture, a zero divisor loads the raw dividend
  // into the remainder and zero into the quotient, with both sign fixes
  // disabled. FIX then produces quotient=0 and remainder=dividend without
  // any extra logic. Otherwise the magnitudes are loaded, along with the
  // result signs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
    end else if (capture) begin
      if (divisor_zero) begin
        count_q    <= '0;
        rem_q      <= dividend;
        quo_q      <= '0;
        dvs_q      <= '0;
        neg_quo_q  <= 1'b0;
        neg_rem_q  <= 1'b0;
        zero_div_q <= 1'b1;
      end else begin
        count_q    <= CW'(WIDTH);
        rem_q      <= '0;
        quo_q      <= dividend_mag;
        dvs_q      <= divisor_mag;
        neg_quo_q  <= dividend_neg ^ divisor_neg;
        neg_rem_q  <= dividend_neg;
        zero_div_q <= 1'b0;
      end
    end else if (state_q == RUN) begin
      count_q <= count_q - CW'(1);
      rem_q   <= rem_next;
      quo_q   <= quo_next;
    end
  end

  // -------------------------------------------------------------------------
  // Architectural results. They are written only in FIX, so they become
  // visible together with done and then hold until the next DONE or reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state_q == FIX) begin
      quotient    <= quo_fixed;
      remainder   <= rem_fixed;
      div_by_zero <= zero_div_q;
    end
  end

endmodule
